// File: rtl/aes_pkg.sv
// Shared AES definitions: block/round constants, FSM encoding and key-bus
// addressing used by the AddRoundKey stage and the round controller.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int NR_AES128   = 10;
  localparam int NR_AES192   = 12;
  localparam int NR_AES256   = 14;

  // Multi-cycle stage sequencing: accept, stream lanes, report.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } aes_fsm_e;

  // LSB position of round key r on a bus of nr+1 keys; round 0 sits in the
  // most significant 128 bits.
  function automatic int rk_offset(input int nr, input int r);
    return AES_BLOCK_W * (nr - r);
  endfunction

  // Width of a counter that indexes 'beats' lanes, never narrower than 1 bit.
  function automatic int beat_cnt_w(input int beats);
    if (beats > 1) begin
      return $clog2(beats);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/aes_roundkey_select.sv
// Round-key selector: picks round key [roundnumber] from the expanded key bus
// and flags an index beyond the last round. Purely combinational.
module aes_roundkey_select
  import aes_pkg::*;
#(
  parameter  int NR    = NR_AES128,
  localparam int KEY_W = AES_BLOCK_W * (NR + 1)
) (
  input  logic [KEY_W-1:0]       key,
  input  logic [3:0]             roundnumber,
  output logic [AES_BLOCK_W-1:0] round_key,
  output logic                   out_of_range
);

  // AND-OR mux over all valid rounds; an out-of-range index yields zero.
  always_comb begin
    round_key    = {AES_BLOCK_W{1'b0}};
    out_of_range = (roundnumber > 4'(NR));
    for (int r = 0; r <= NR; r++) begin
      round_key = round_key |
                  (key[rk_offset(NR, r) +: AES_BLOCK_W] &
                   {AES_BLOCK_W{roundnumber == 4'(r)}});
    end
  end

endmodule

// File: rtl/aes_addroundkey_mc.sv
// Multi-cycle AddRoundKey: XORs the selected round key into a 128-bit state,
// LANE_W bits per cycle starting at the most significant lane. A start pulse
// accepted in IDLE snapshots state and key, so later input changes cannot
// disturb the running block. result only moves when a block completes.
module aes_addroundkey_mc
  import aes_pkg::*;
#(
  parameter  int NR     = NR_AES128,
  parameter  int LANE_W = 32,
  localparam int KEY_W  = AES_BLOCK_W * (NR + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AES_BLOCK_W-1:0] state,
  input  logic [KEY_W-1:0]       key,
  input  logic [3:0]             roundnumber,
  input  logic                   start,
  output logic [AES_BLOCK_W-1:0] result,
  output logic                   busy,
  output logic                   finish,
  output logic                   err
);

  localparam int BEATS  = AES_BLOCK_W / LANE_W;
  localparam int BEAT_W = beat_cnt_w(BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  aes_fsm_e               fsm_r;
  aes_fsm_e               fsm_nx_s;
  logic [BEAT_W-1:0]      beat_r;
  logic [AES_BLOCK_W-1:0] wstate_r;
  logic [AES_BLOCK_W-1:0] wstate_nx_s;
  logic [AES_BLOCK_W-1:0] wkey_r;
  logic                   err_flag_r;
  logic [AES_BLOCK_W-1:0] result_r;
  logic                   busy_r;
  logic                   finish_r;
  logic                   err_r;
  logic [AES_BLOCK_W-1:0] rk_s;
  logic                   rk_oor_s;

  aes_roundkey_select #(
    .NR (NR)
  ) u_rk_sel (
    .key          (key),
    .roundnumber  (roundnumber),
    .round_key    (rk_s),
    .out_of_range (rk_oor_s)
  );

  // Next FSM state: bad round skips straight to DONE to report the error.
  always_comb begin
    fsm_nx_s = fsm_r;
    case (fsm_r)
      ST_IDLE: begin
        if (start) begin
          if (rk_oor_s) begin
            fsm_nx_s = ST_DONE;
          end else begin
            fsm_nx_s = ST_RUN;
          end
        end else begin
          fsm_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (beat_r == LAST_BEAT) begin
          fsm_nx_s = ST_DONE;
        end else begin
          fsm_nx_s = ST_RUN;
        end
      end
      ST_DONE: fsm_nx_s = ST_IDLE;
      default: fsm_nx_s = ST_IDLE;
    endcase
  end

  // Work state with the current lane XORed by its round-key lane.
  always_comb begin
    wstate_nx_s = wstate_r;
    for (int i = 0; i < BEATS; i++) begin
      if (beat_r == BEAT_W'(i)) begin
        wstate_nx_s[AES_BLOCK_W-1-i*LANE_W -: LANE_W] =
          wstate_r[AES_BLOCK_W-1-i*LANE_W -: LANE_W] ^
          wkey_r[AES_BLOCK_W-1-i*LANE_W -: LANE_W];
      end else begin
        wstate_nx_s[AES_BLOCK_W-1-i*LANE_W -: LANE_W] =
          wstate_r[AES_BLOCK_W-1-i*LANE_W -: LANE_W];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm_r <= ST_IDLE;
    end else begin
      fsm_r <= fsm_nx_s;
    end
  end

  // Datapath and registered status: snapshot on accept, stream lanes in RUN,
  // publish in DONE (result held on the error path).
  always_ff @(posedge clk) begin
    if (!rst) begin
      beat_r     <= {BEAT_W{1'b0}};
      wstate_r   <= {AES_BLOCK_W{1'b0}};
      wkey_r     <= {AES_BLOCK_W{1'b0}};
      err_flag_r <= 1'b0;
      result_r   <= {AES_BLOCK_W{1'b0}};
      busy_r     <= 1'b0;
      finish_r   <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      busy_r   <= (fsm_nx_s != ST_IDLE);
      finish_r <= (fsm_r == ST_DONE);
      err_r    <= (fsm_r == ST_DONE) && err_flag_r;
      case (fsm_r)
        ST_IDLE: begin
          if (start) begin
            if (rk_oor_s) begin
              err_flag_r <= 1'b1;
            end else begin
              wstate_r   <= state;
              wkey_r     <= rk_s;
              beat_r     <= {BEAT_W{1'b0}};
              err_flag_r <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          wstate_r <= wstate_nx_s;
          beat_r   <= beat_r + BEAT_W'(1);
        end
        ST_DONE: begin
          if (!err_flag_r) begin
            result_r <= wstate_r;
          end else begin
            result_r <= result_r;
          end
          err_flag_r <= 1'b0;
        end
        default: begin
          err_flag_r <= 1'b0;
        end
      endcase
    end
  end

  assign result = result_r;
  assign busy   = busy_r;
  assign finish = finish_r;
  assign err    = err_r;

endmodule
